sam_param: RTL



---
 rtl/sam_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sam_param.sv
// sam_param: parametrised sequential shift-and-add multiplier.
// Operands are WIDTH bits and Product is 2*WIDTH bits. Signed mode works on
// operand magnitudes and then applies the result sign. Start/Done is a level
// handshake, and Busy is high while the iterations run.
// Optional build macro SAM_EARLY_EXIT_EN: when defined, the operation also
// finalizes on the first WORK edge after which the shifted multiplier is zero.
module sam_param #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Done,
    output logic                 Busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WORK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mult_q;
    logic [CW-1:0]   count_q;
    logic            res_neg_q;

    // Operand magnitudes and result sign, used only on the accept edge.
    // In unsigned mode the raw values pass through unchanged.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = Signed & Multiplicand[WIDTH-1];
    assign b_neg = Signed & Multiplier[WIDTH-1];
    // Negating the most negative value wraps back to 2^(WIDTH-1), which is
    // exactly the magnitude wanted when read as unsigned.
    assign a_mag = a_neg ? (~Multiplicand + WIDTH'(1)) : Multiplicand;
    assign b_mag = b_neg ? (~Multiplier + WIDTH'(1)) : Multiplier;

    // One shift-and-add iteration. The finalized result is derived from the
    // accumulator including this iteration so no extra cycle is needed.
    logic [PW-1:0]    acc_add;
    logic [PW-1:0]    acc_neg;
    logic [WIDTH-1:0] mult_shift;
    logic             count_last;
    logic             finish;

    assign acc_add    = mult_q[0] ? (acc_q + mcand_q) : acc_q;
    assign acc_neg    = ~acc_add + PW'(1);
    assign mult_shift = mult_q >> 1;
    assign count_last = (count_q == CW'(WIDTH - 1));

`ifdef SAM_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations cannot change acc.
    assign finish = count_last || (mult_shift == '0);
`else
    assign finish = count_last;
`endif

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge Clock) begin
        // NOTE: every register here uses non-blocking assignment so all of
        // them update from the same pre-edge values.
        if (!Reset_n) begin
            state     <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            count_q   <= '0;
            res_neg_q <= 1'b0;
            Product   <= '0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        mcand_q   <= {{WIDTH{1'b0}}, a_mag};
                        mult_q    <= b_mag;
                        res_neg_q <= a_neg ^ b_neg;
                        acc_q     <= '0;
                        count_q   <= '0;
                        Busy      <= 1'b1;
                        state     <= S_WORK;
                    end
                end

                S_WORK: begin
                    acc_q   <= acc_add;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_shift;
                    count_q <= count_q + CW'(1);
                    if (finish) begin
                        // A zero accumulator negates to zero, so a negative
                        // sign on a zero product is harmless.
                        Product <= res_neg_q ? acc_neg : acc_add;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!Start) begin
                        Done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
